// File: rtl/breadboard_inverse_scanner_pkg.sv
// Shared definitions for the breadboard inverse scanner.
// Holds the scanner state enumeration, the code/index widths, the table
// depth, and the bit position of each breadboard drive line within the
// 4-bit input index (w is the MSB, z the LSB).
package breadboard_inverse_scanner_pkg;

  localparam int unsigned CODE_W      = 10;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned TABLE_DEPTH = 16;

  // Position of each drive line within the input index.
  localparam int unsigned DRV_W_BIT = 3;
  localparam int unsigned DRV_X_BIT = 2;
  localparam int unsigned DRV_Y_BIT = 1;
  localparam int unsigned DRV_Z_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_READY,
    ST_SEARCH,
    ST_RESPOND
  } scan_state_t;

endpackage

// File: rtl/breadboard_code_table.sv
// 16 x CODE_W register file holding the captured breadboard responses.
// Ports:
//   clk        - system clock
//   i_wr_en    - write strobe (capture)
//   i_wr_idx   - write index
//   i_wr_data  - captured response
//   i_rd_idx   - read index (scan)
//   o_rd_data  - registered read data, one cycle after i_rd_idx
// Contents are not reset; the owner tracks validity separately.
module breadboard_code_table
  import breadboard_inverse_scanner_pkg::*;
#(
  parameter int unsigned DATA_W = CODE_W,
  parameter int unsigned ADDR_W = IDX_W
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/breadboard_inverse_scanner.sv
// Breadboard inverse scanner.
// Sweeps all 16 input combinations onto w,x,y,z, captures each response
// into a table, then answers queries mapping a response code back to the
// lowest input index that produced it (plus hit / aliased-code flags).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - pulse: (re)build the table (IDLE/READY only)
//   w, x, y, z            - breadboard drive (index bits 3..0)
//   resp                  - breadboard outputs r0..r9
//   table_valid           - table fully built
//   sweep_done            - one-cycle pulse after the last capture
//   q_valid/q_ready/q_code           - query channel
//   res_valid/res_ready/res_hit/res_idx/res_multi - result channel
module breadboard_inverse_scanner
  import breadboard_inverse_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              w,
  output logic              x,
  output logic              y,
  output logic              z,
  input  logic [CODE_W-1:0] resp,
  output logic              table_valid,
  output logic              sweep_done,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [CODE_W-1:0] q_code,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [IDX_W-1:0]  res_idx,
  output logic              res_multi
);

  localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W:0] SCAN_LAST   = (IDX_W+1)'(TABLE_DEPTH);

  scan_state_t       r_state;
  scan_state_t       w_next;

  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_settle;
  logic [IDX_W-1:0]  r_drive;
  logic              r_table_valid;
  logic              r_sweep_done;
  logic [CODE_W-1:0] r_q_code;
  logic [IDX_W:0]    r_scan_cnt;
  logic              r_hit;
  logic              r_multi;
  logic [IDX_W-1:0]  r_res_idx;

  logic [CODE_W-1:0] w_rd_data;
  logic [IDX_W-1:0]  w_cmp_idx;
  logic              w_match;
  logic              w_scan_last;
  logic              w_last_entry;

  breadboard_code_table #(
    .DATA_W (CODE_W),
    .ADDR_W (IDX_W)
  ) u_table (
    .clk       (clk),
    .i_wr_en   (r_state == ST_CAPTURE),
    .i_wr_idx  (r_idx),
    .i_wr_data (resp),
    .i_rd_idx  (r_scan_cnt[IDX_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  // The read port is registered, so while scanning the data on w_rd_data
  // belongs to entry r_scan_cnt-1; count 0 only primes the read and count
  // 16 compares the final entry (its low bits wrap to 0, minus one = 15).
  assign w_cmp_idx    = r_scan_cnt[IDX_W-1:0] - IDX_W'(1);
  assign w_scan_last  = (r_scan_cnt == SCAN_LAST);
  assign w_match      = (r_state == ST_SEARCH) && (r_scan_cnt != '0) &&
                        (w_rd_data == r_q_code);
  assign w_last_entry = (r_idx == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_DRIVE;
      ST_DRIVE:   w_next = ST_SETTLE;
      ST_SETTLE:  if (r_settle == '0) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = w_last_entry ? ST_READY : ST_DRIVE;
      ST_READY: begin
        if (start) begin
          w_next = ST_DRIVE;
        end else if (q_valid) begin
          w_next = ST_SEARCH;
        end
      end
      ST_SEARCH:  if (w_scan_last) w_next = ST_RESPOND;
      ST_RESPOND: if (res_ready) w_next = ST_READY;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_settle      <= '0;
      r_drive       <= '0;
      r_table_valid <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_q_code      <= '0;
      r_scan_cnt    <= '0;
      r_hit         <= 1'b0;
      r_multi       <= 1'b0;
      r_res_idx     <= '0;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx         <= '0;
            r_table_valid <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_drive  <= r_idx;
          r_settle <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - 4'd1;
          end
        end
        ST_CAPTURE: begin
          if (w_last_entry) begin
            r_sweep_done  <= 1'b1;
            r_table_valid <= 1'b1;
            r_drive       <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_READY: begin
          if (start) begin
            r_idx         <= '0;
            r_table_valid <= 1'b0;
          end else if (q_valid) begin
            r_q_code   <= q_code;
            r_scan_cnt <= '0;
            r_hit      <= 1'b0;
            r_multi    <= 1'b0;
            r_res_idx  <= '0;
          end
        end
        ST_SEARCH: begin
          r_scan_cnt <= r_scan_cnt + (IDX_W+1)'(1);
          if (w_match) begin
            if (!r_hit) begin
              r_hit     <= 1'b1;
              r_res_idx <= w_cmp_idx;
            end else begin
              r_multi <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w           = r_drive[DRV_W_BIT];
  assign x           = r_drive[DRV_X_BIT];
  assign y           = r_drive[DRV_Y_BIT];
  assign z           = r_drive[DRV_Z_BIT];
  assign table_valid = r_table_valid;
  assign sweep_done  = r_sweep_done;
  assign q_ready     = (r_state == ST_READY);
  assign res_valid   = (r_state == ST_RESPOND);
  assign res_hit     = r_hit;
  assign res_idx     = r_res_idx;
  assign res_multi   = r_multi;

endmodule

// File: tb/tb_breadboard_inverse_scanner.sv
module tb_breadboard_inverse_scanner;

  localparam int unsigned SETTLE = 3;
  localparam int unsigned PERIOD = SETTLE + 2;
  localparam int unsigned SWEEP  = 16 * PERIOD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       w, x, y, z;
  logic [9:0] resp;
  logic       table_valid;
  logic       sweep_done;
  logic       q_valid;
  logic       q_ready;
  logic [9:0] q_code;
  logic       res_valid;
  logic       res_ready;
  logic       res_hit;
  logic [3:0] res_idx;
  logic       res_multi;

  int         mode;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] model_tbl [16];
  logic       model_valid;
  logic       armed;
  logic       exp_hit;
  logic [3:0] exp_idx;
  logic       exp_multi;

  always #5 clk = ~clk;

  breadboard_inverse_scanner #(
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .w           (w),
    .x           (x),
    .y           (y),
    .z           (z),
    .resp        (resp),
    .table_valid (table_valid),
    .sweep_done  (sweep_done),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_code      (q_code),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hit     (res_hit),
    .res_idx     (res_idx),
    .res_multi   (res_multi)
  );

  // Responders: 0 = breadboard function, 1 = identity stub, 2 = aliasing stub.
  function automatic logic [9:0] respond(input int m, input logic [3:0] i);
    logic [9:0] r;
    if (m == 0) begin
      case (i)
        4'd0:  r = 10'h194;  4'd1:  r = 10'h0A3;
        4'd2:  r = 10'h151;  4'd3:  r = 10'h2C8;
        4'd4:  r = 10'h03E;  4'd5:  r = 10'h1E7;
        4'd6:  r = 10'h219;  4'd7:  r = 10'h0F0;
        4'd8:  r = 10'h30C;  4'd9:  r = 10'h17B;
        4'd10: r = 10'h2A5;  4'd11: r = 10'h05D;
        4'd12: r = 10'h392;  4'd13: r = 10'h1C6;
        4'd14: r = 10'h0B9;  default: r = 10'h266;
      endcase
    end else if (m == 1) begin
      r = {6'b0, i};
    end else begin
      r = {6'b0, i[3:1], 1'b0};
    end
    return r;
  endfunction

  assign resp = respond(mode, {w, x, y, z});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inverse lookup straight from the captured table contents.
  task automatic model_query(input logic [9:0] code, output logic h,
                             output logic [3:0] ix, output logic mu);
    int cnt;
    cnt = 0;
    ix  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (model_valid && model_tbl[i] == code) begin
        if (cnt == 0) ix = 4'(i);
        cnt++;
      end
    end
    h  = (cnt > 0);
    mu = (cnt > 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && armed && res_valid) begin
      chk("res_hit_vs_model",   32'(res_hit),   32'(exp_hit));
      chk("res_idx_vs_model",   32'(res_idx),   32'(exp_idx));
      chk("res_multi_vs_model", 32'(res_multi), 32'(exp_multi));
    end
  end

  task automatic run_sweep(input bit with_query);
    int k, done_at, bad;
    logic [3:0] e;
    @(negedge clk);
    start = 1'b1;
    if (with_query) begin
      q_valid = 1'b1;
      q_code  = 10'h194;
    end
    @(posedge clk); #1;
    start   = 1'b0;
    q_valid = 1'b0;
    k = 0; done_at = 0; bad = 0;
    while (k < int'(SWEEP) + 20 && done_at == 0) begin
      @(posedge clk); #1;
      k++;
      e = (k < int'(SWEEP)) ? 4'((k - 1) / int'(PERIOD)) : 4'd0;
      if ({w, x, y, z} !== e) bad++;
      if (q_ready !== (k == int'(SWEEP))) bad++;
      if (res_valid !== 1'b0) bad++;
      if (table_valid !== (k >= int'(SWEEP))) bad++;
      if (sweep_done) done_at = k;
      start = (k == 30);  // must be ignored mid-sweep
    end
    start = 1'b0;
    chk("sweep_done_cycle", 32'(done_at), 32'(SWEEP));
    chk("sweep_drive_seq", 32'(bad), 32'd0);
    chk("table_valid_after_sweep", 32'(table_valid), 32'd1);
    @(posedge clk); #1;
    chk("sweep_done_one_pulse", 32'(sweep_done), 32'd0);
    for (int i = 0; i < 16; i++) model_tbl[i] = respond(mode, 4'(i));
    model_valid = 1'b1;
  endtask

  task automatic query(input logic [9:0] code, input logic lh, input logic [3:0] li,
                       input logic lm, input int hold);
    int lat, qr_bad, stab_bad;
    logic [5:0] snap;
    model_query(code, exp_hit, exp_idx, exp_multi);
    chk("model_pin_hit",   32'(exp_hit),   32'(lh));
    chk("model_pin_idx",   32'(exp_idx),   32'(li));
    chk("model_pin_multi", 32'(exp_multi), 32'(lm));
    @(negedge clk);
    q_code  = code;
    q_valid = 1'b1;
    armed   = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    lat = 0; qr_bad = 0;
    while (!res_valid && lat < 40) begin
      if (q_ready) qr_bad++;
      @(posedge clk); #1;
      lat++;
    end
    chk("query_latency", 32'(lat), 32'd17);
    chk("q_ready_low_in_search", 32'(qr_bad), 32'd0);
    chk("res_direct", 32'({res_hit, res_idx, res_multi}), 32'({lh, li, lm}));
    snap = {res_hit, res_idx, res_multi};
    stab_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!res_valid || q_ready || {res_hit, res_idx, res_multi} != snap) stab_bad++;
    end
    if (hold > 0) chk("res_hold_stable", 32'(stab_bad), 32'd0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    armed     = 1'b0;
    chk("handshake_to_ready", 32'({res_valid, q_ready}), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad;
    rst_n = 1'b0; start = 1'b0; q_valid = 1'b0; q_code = '0; res_ready = 1'b0;
    mode = 0; armed = 1'b0; model_valid = 1'b0;
    exp_hit = 1'b0; exp_idx = '0; exp_multi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({w, x, y, z, table_valid, sweep_done, q_ready, res_valid,
                              res_hit, res_idx, res_multi}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(1'b0);
    query(10'h194, 1'b1, 4'd0,  1'b0, 0);
    query(10'h266, 1'b1, 4'd15, 1'b0, 5);

    mode = 1;
    run_sweep(1'b1);  // start beats a simultaneous query
    query(10'h3FF, 1'b0, 4'd0, 1'b0, 0);

    mode = 2;
    run_sweep(1'b0);
    query(10'h004, 1'b1, 4'd4,  1'b1, 0);
    query(10'h00E, 1'b1, 4'd14, 1'b1, 2);

    // Reset in the middle of a sweep.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ({w, x, y, z} != 4'd7 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_entry7", 32'({w, x, y, z}), 32'd7);
    #2;
    rst_n = 1'b0;
    model_valid = 1'b0;
    #1;
    chk("async_reset_mid_sweep", 32'({w, x, y, z, table_valid, sweep_done, q_ready, res_valid,
                                      res_hit, res_idx, res_multi}), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    q_valid = 1'b1;
    q_code  = 10'h194;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (q_ready || res_valid || table_valid) bad++;
    end
    q_valid = 1'b0;
    chk("idle_ignores_query", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
